// File: rtl/mdio_pkg.sv
// Shared constants, FSM state type and frame-type decode for the MDIO master.
package mdio_pkg;

  localparam logic [1:0] ST_C22       = 2'b01;
  localparam logic [1:0] ST_C45       = 2'b00;
  localparam logic [1:0] OP_C22_WR    = 2'b01;
  localparam logic [1:0] OP_C22_RD    = 2'b10;
  localparam logic [1:0] OP_C45_ADDR  = 2'b00;
  localparam logic [1:0] OP_C45_WR    = 2'b01;
  localparam logic [1:0] OP_C45_RDINC = 2'b10;
  localparam logic [1:0] OP_C45_RD    = 2'b11;

  // Bit counters are loaded with (phase length - 1) and count down to zero
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4
  } mdio_state_e;

  // A frame is read-type when the PHY must drive the data phase back to us
  function automatic logic is_read_frame(input logic [1:0] st, input logic [1:0] op,
                                         input logic c45En);
    return ((st == ST_C22) && (op == OP_C22_RD)) ||
           (c45En && (st == ST_C45) && op[1]);
  endfunction

endpackage

// File: rtl/mdio_master_gen_mdc_clk_div.sv
// MDC generator: divides clk by 2*DIV while enabled and flags the clk edges
// on which MDC rises and falls. When disabled it parks low at phase zero, so
// every frame begins with a full-length low half-period.
module mdc_clk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic MDC,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] r_divCnt;
  logic       r_mdc;
  logic       w_wrap;

  assign w_wrap = en && (r_divCnt == LAST);

  // Count clk cycles within each MDC half-period and toggle MDC at the wrap
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_divCnt <= '0;
      r_mdc    <= 1'b0;
    end else if (w_wrap) begin
      r_divCnt <= '0;
      r_mdc    <= ~r_mdc;
    end else begin
      r_divCnt <= r_divCnt + 8'd1;
    end
  end

  assign MDC        = r_mdc;
  assign rise_pulse = w_wrap && !r_mdc;
  assign fall_pulse = w_wrap && r_mdc;

endmodule

// File: rtl/mdio_master_gen.sv
// MDIO management-frame master: serialises a captured 32-bit frame (with an
// optional preamble) onto the pad, turns the line around for read frames and
// returns the 16 data bits sampled from the PHY.
module mdio_master_gen
  import mdio_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int PRE_LEN = 32,
  parameter int C45_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_START,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT,
  output logic        BUSY,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        RD_ERR
);

  localparam int         PRE_LOAD_I = (PRE_LEN > 0) ? (PRE_LEN - 1) : 0;
  localparam logic [5:0] PRE_LOAD   = 6'(PRE_LOAD_I);

  mdio_state_e r_state;
  logic [5:0]  r_bitCnt;
  logic [31:0] r_frame;
  logic        r_isRead;
  logic [15:0] r_rx;
  logic        r_taErr;
  logic        r_oe;
  logic        r_out;
  logic        r_busy;
  logic [15:0] r_rdData;
  logic        r_dataRdy;
  logic        r_rdErr;

  logic w_mdc;
  logic w_rise;
  logic w_fall;

  mdc_clk_div #(.DIV(DIV)) u_mdcDiv (
    .clk        (clk),
    .rst        (rst),
    .en         (r_busy),
    .MDC        (w_mdc),
    .rise_pulse (w_rise),
    .fall_pulse (w_fall)
  );

  // Frame sequencer: r_frame[31] is always the next bit to put on the line,
  // and each MDC falling edge (end of the current bit) presents the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bitCnt  <= '0;
      r_frame   <= '0;
      r_isRead  <= 1'b0;
      r_rx      <= '0;
      r_taErr   <= 1'b0;
      r_oe      <= 1'b0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdData  <= '0;
      r_dataRdy <= 1'b0;
      r_rdErr   <= 1'b0;
    end else begin
      r_dataRdy <= 1'b0;
      r_rdErr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MDIO_START) begin
            r_busy   <= 1'b1;
            r_oe     <= 1'b1;
            r_isRead <= is_read_frame(T_DATA[31:30], T_DATA[29:28], C45_EN != 0);
            if (PRE_LEN > 0) begin
              r_state  <= S_PRE;
              r_bitCnt <= PRE_LOAD;
              r_frame  <= T_DATA;
              r_out    <= 1'b1;
            end else begin
              r_state  <= S_HDR;
              r_bitCnt <= HDR_LAST;
              r_frame  <= {T_DATA[30:0], 1'b0};
              r_out    <= T_DATA[31];
            end
          end
        end

        S_PRE: begin
          if (w_fall) begin
            if (r_bitCnt == 6'd0) begin
              r_state  <= S_HDR;
              r_bitCnt <= HDR_LAST;
              r_out    <= r_frame[31];
              r_frame  <= {r_frame[30:0], 1'b0};
            end else begin
              r_bitCnt <= r_bitCnt - 6'd1;
            end
          end
        end

        S_HDR: begin
          if (w_fall) begin
            r_frame <= {r_frame[30:0], 1'b0};
            if (r_bitCnt == 6'd0) begin
              r_state  <= S_TA;
              r_bitCnt <= TA_LAST;
              r_oe     <= !r_isRead;
              r_out    <= r_isRead ? 1'b0 : r_frame[31];
            end else begin
              r_bitCnt <= r_bitCnt - 6'd1;
              r_out    <= r_frame[31];
            end
          end
        end

        S_TA: begin
          if (w_rise && (r_bitCnt == 6'd0)) begin
            r_taErr <= MDIO_IN;
          end
          if (w_fall) begin
            r_frame <= {r_frame[30:0], 1'b0};
            r_out   <= r_isRead ? 1'b0 : r_frame[31];
            if (r_bitCnt == 6'd0) begin
              r_state  <= S_DATA;
              r_bitCnt <= DATA_LAST;
            end else begin
              r_bitCnt <= r_bitCnt - 6'd1;
            end
          end
        end

        S_DATA: begin
          if (w_rise && r_isRead) begin
            r_rx <= {r_rx[14:0], MDIO_IN};
          end
          if (w_fall) begin
            if (r_bitCnt == 6'd0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_oe    <= 1'b0;
              r_out   <= 1'b0;
              if (r_isRead) begin
                r_rdData  <= r_rx;
                r_dataRdy <= 1'b1;
                r_rdErr   <= r_taErr;
              end
            end else begin
              r_bitCnt <= r_bitCnt - 6'd1;
              r_frame  <= {r_frame[30:0], 1'b0};
              r_out    <= r_isRead ? 1'b0 : r_frame[31];
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_oe    <= 1'b0;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  assign MDC      = w_mdc;
  assign MDIO_OE  = r_oe;
  assign MDIO_OUT = r_out;
  assign BUSY     = r_busy;
  assign RD_DATA  = r_rdData;
  assign DATA_RDY = r_dataRdy;
  assign RD_ERR   = r_rdErr;

endmodule

// File: tb/tb_mdio_master_gen.sv
// Testbench for mdio_master_gen: three instances with different DIV/PRE_LEN/
// C45_EN settings, checked cycle by cycle against a bit-list model of the frame.
module tb_mdio_master_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, start, mdioIn;
  logic [2:0]       mdc, oe, out, busy, rdy, err;
  logic [2:0][31:0] tdata;
  logic [2:0][15:0] rdData;

  int         divTab [3] = '{1, 2, 3};
  int         preTab [3] = '{0, 32, 2};
  bit         c45Tab [3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] lastRd [3];

  int checks   = 0;
  int failures = 0;
  int busyRise0 = 0;

  mdio_master_gen #(.DIV(1), .PRE_LEN(0), .C45_EN(1)) dutA (
    .clk(clk), .rst(rst[0]), .T_DATA(tdata[0]), .MDIO_START(start[0]), .MDIO_IN(mdioIn[0]),
    .MDC(mdc[0]), .MDIO_OE(oe[0]), .MDIO_OUT(out[0]), .BUSY(busy[0]),
    .RD_DATA(rdData[0]), .DATA_RDY(rdy[0]), .RD_ERR(err[0]));

  mdio_master_gen #(.DIV(2), .PRE_LEN(32), .C45_EN(1)) dutB (
    .clk(clk), .rst(rst[1]), .T_DATA(tdata[1]), .MDIO_START(start[1]), .MDIO_IN(mdioIn[1]),
    .MDC(mdc[1]), .MDIO_OE(oe[1]), .MDIO_OUT(out[1]), .BUSY(busy[1]),
    .RD_DATA(rdData[1]), .DATA_RDY(rdy[1]), .RD_ERR(err[1]));

  mdio_master_gen #(.DIV(3), .PRE_LEN(2), .C45_EN(0)) dutC (
    .clk(clk), .rst(rst[2]), .T_DATA(tdata[2]), .MDIO_START(start[2]), .MDIO_IN(mdioIn[2]),
    .MDC(mdc[2]), .MDIO_OE(oe[2]), .MDIO_OUT(out[2]), .BUSY(busy[2]),
    .RD_DATA(rdData[2]), .DATA_RDY(rdy[2]), .RD_ERR(err[2]));

  // Count frames started on the first instance
  always @(posedge busy[0]) busyRise0++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit modelIsRead(input logic [31:0] td, input bit c45);
    logic [1:0] st;
    logic [1:0] op;
    st = td[31:30];
    op = td[29:28];
    return ((st == 2'b01) && (op == 2'b10)) || (c45 && (st == 2'b00) && op[1]);
  endfunction

  // Line value for bit k of the whole transmission: preamble ones, then the frame MSB first
  function automatic logic modelBit(input int pre, input int k, input logic [31:0] td);
    if (k < pre) return 1'b1;
    return td[31 - (k - pre)];
  endfunction

  // What the PHY drives during bit k: pulled-up 1, TA second bit, then data MSB first
  function automatic logic phyBit(input int pre, input int k, input bit isRd,
                                  input logic [15:0] phy, input logic ta);
    if (!isRd) return 1'b1;
    if (k == pre + 15) return ta;
    if (k >= pre + 16) return phy[15 - (k - pre - 16)];
    return 1'b1;
  endfunction

  // Run one frame on instance idx; returns at the negedge of the cycle BUSY drops
  // (or just after an abort reset). midStartAt/abortAt are cycle offsets from the
  // first bit, -1 to disable.
  task automatic applyStimulus(input int idx, input logic [31:0] td, input logic [15:0] phy,
                               input logic ta, input bit startNow, input int midStartAt,
                               input int abortAt, output bit gotRdy,
                               output logic [15:0] gotRd, output bit gotErr);
    int div, pre, len, k, ph;
    int eMdc, eOe, eOut, eBusy, eRdy;
    bit isRd, expMdc, expOe, expOut, aborted;
    div = divTab[idx];
    pre = preTab[idx];
    len = (pre + 32) * 2 * div;
    isRd = modelIsRead(td, c45Tab[idx]);
    eMdc = 0; eOe = 0; eOut = 0; eBusy = 0; eRdy = 0;
    aborted = 1'b0;
    gotRdy = 1'b0; gotErr = 1'b0; gotRd = 16'h0;
    if (!startNow) @(negedge clk);
    start[idx] = 1'b1;
    tdata[idx] = td;
    @(negedge clk);
    start[idx] = 1'b0;
    tdata[idx] = $urandom;
    for (int t = 0; t < len; t++) begin
      start[idx] = 1'b0;
      k = t / (2 * div);
      ph = t % (2 * div);
      expMdc = (ph >= div);
      expOe  = !isRd || (k < pre + 14);
      expOut = expOe ? modelBit(pre, k, td) : 1'b0;
      mdioIn[idx] = phyBit(pre, k, isRd, phy, ta);
      if (mdc[idx] !== expMdc) eMdc++;
      if (oe[idx] !== expOe) eOe++;
      if (out[idx] !== expOut) eOut++;
      if (busy[idx] !== 1'b1) eBusy++;
      if (rdy[idx] !== 1'b0 || err[idx] !== 1'b0) eRdy++;
      if (t == midStartAt) begin
        start[idx] = 1'b1;
        tdata[idx] = $urandom;
      end
      if (t == abortAt) begin
        rst[idx] = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("d%0d_abort_ctl", idx),
                    {29'h0, mdc[idx], oe[idx], out[idx]}, 32'h0);
        checkOutput($sformatf("d%0d_abort_stat", idx),
                    {29'h0, busy[idx], rdy[idx], err[idx]}, 32'h0);
        checkOutput($sformatf("d%0d_abort_rddata", idx), rdData[idx], 32'h0);
        rst[idx] = 1'b0;
        lastRd[idx] = 16'h0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start[idx] = 1'b0;
    mdioIn[idx] = 1'b1;
    checkOutput($sformatf("d%0d_mdc_seq_errs", idx), eMdc, 32'h0);
    checkOutput($sformatf("d%0d_oe_seq_errs", idx), eOe, 32'h0);
    checkOutput($sformatf("d%0d_out_seq_errs", idx), eOut, 32'h0);
    checkOutput($sformatf("d%0d_busy_seq_errs", idx), eBusy, 32'h0);
    checkOutput($sformatf("d%0d_early_rdy_errs", idx), eRdy, 32'h0);
    if (!aborted) begin
      checkOutput($sformatf("d%0d_end_busy", idx), busy[idx], 32'h0);
      checkOutput($sformatf("d%0d_end_line", idx), {29'h0, mdc[idx], oe[idx], out[idx]}, 32'h0);
      checkOutput($sformatf("d%0d_end_rdy", idx), rdy[idx], {31'h0, isRd});
      checkOutput($sformatf("d%0d_end_err", idx), err[idx], {31'h0, isRd & ta});
      checkOutput($sformatf("d%0d_end_rddata", idx), rdData[idx], isRd ? phy : lastRd[idx]);
      if (isRd) lastRd[idx] = phy;
      gotRdy = rdy[idx];
      gotErr = err[idx];
      gotRd  = rdData[idx];
    end
  endtask

  // Idle line: no MDC edges, pad released, no status pulses
  task automatic idleCheck(input int idx, input int n);
    int e;
    e = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({mdc[idx], oe[idx], out[idx], busy[idx], rdy[idx], err[idx]} !== 6'b0) e++;
    end
    checkOutput($sformatf("d%0d_idle_errs", idx), e, 32'h0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] td;
    logic [15:0] phy;
    logic        ta;
    bit          expRead;
    logic [15:0] expRd;
    bit          expErr;
  } vec_t;

  vec_t        vecs [7];
  bit          gRdy, gErr;
  logic [15:0] gRd;
  logic [3:0]  picks [3] = '{4'b0110, 4'b0011, 4'b0010};

  initial begin
    vecs[0] = '{0, 32'h9536_AE53, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1, 32'h6A36_0000, 16'hA5C3, 1'b0, 1'b1, 16'hA5C3, 1'b0};
    vecs[2] = '{1, 32'h6A36_0000, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{0, 32'h3123_0000, 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0};
    vecs[4] = '{2, 32'h3123_0000, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{2, 32'h6A36_0000, 16'h5A0F, 1'b0, 1'b1, 16'h5A0F, 1'b0};
    vecs[6] = '{0, 32'h0123_4567, 16'h9999, 1'b0, 1'b0, 16'h1234, 1'b0};

    rst = 3'b111; start = 3'b000; mdioIn = 3'b111; tdata = '0;
    for (int i = 0; i < 3; i++) lastRd[i] = 16'h0;
    repeat (3) @(negedge clk);
    start = 3'b111;
    tdata = {32'h6A36_0000, 32'h6A36_0000, 32'h6A36_0000};
    @(negedge clk);
    start = 3'b000;
    rst = 3'b000;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("d%0d_reset_state", i),
                  {10'h0, mdc[i], oe[i], out[i], busy[i], rdy[i], err[i], rdData[i]}, 32'h0);
    end
    idleCheck(0, 2);

    $display("[TB] table vectors");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].idx, vecs[v].td, vecs[v].phy, vecs[v].ta, 1'b0, -1, -1, gRdy, gRd, gErr);
      checkOutput($sformatf("vec%0d_rdy", v), gRdy, {31'h0, vecs[v].expRead});
      checkOutput($sformatf("vec%0d_rddata", v), gRd, vecs[v].expRd);
      checkOutput($sformatf("vec%0d_err", v), gErr, {31'h0, vecs[v].expErr});
      idleCheck(vecs[v].idx, 4);
    end

    $display("[TB] back-to-back C45 address then read");
    busyRise0 = 0;
    applyStimulus(0, 32'h0123_4567, 16'h0, 1'b0, 1'b0, 7, -1, gRdy, gRd, gErr);
    checkOutput("b2b_first_rdy", gRdy, 32'h0);
    applyStimulus(0, 32'h3123_0000, 16'hBEEF, 1'b0, 1'b1, 30, -1, gRdy, gRd, gErr);
    checkOutput("b2b_second_rdy", gRdy, 32'h1);
    checkOutput("b2b_second_rddata", gRd, 32'h0000_BEEF);
    idleCheck(0, 10);
    checkOutput("b2b_frame_count", busyRise0, 32'd2);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 32'h6A36_0000, 16'hC0DE, 1'b0, 1'b0, -1, 20 * 2 * 2, gRdy, gRd, gErr);
    idleCheck(1, 6);
    applyStimulus(1, 32'h6A36_0000, 16'h0F0F, 1'b0, 1'b0, -1, -1, gRdy, gRd, gErr);
    checkOutput("post_reset_rddata", gRd, 32'h0000_0F0F);
    idleCheck(1, 3);

    $display("[TB] randomized frames");
    for (int r = 0; r < 9; r++) begin
      int          idx;
      logic [31:0] td;
      logic [15:0] phy;
      logic        ta;
      idx = r % 3;
      td = $urandom;
      if ($urandom_range(1, 0) == 1) td[31:28] = picks[$urandom_range(2, 0)];
      phy = 16'($urandom);
      ta = ($urandom_range(3, 0) == 0);
      applyStimulus(idx, td, phy, ta, 1'b0, -1, -1, gRdy, gRd, gErr);
      idleCheck(idx, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
